// File: rtl/alu_capture_if.sv
// Handshake bundle between the ALU/consumer side (master) and the result capture block (slave).
// Member names follow the ALU's own signal names so instances wire up one-to-one.
interface alu_capture_if #(
  parameter int N = 4
);
  logic [N-1:0] ALU_Out;
  logic         Negative;
  logic         Zero;
  logic         CarryOut;
  logic         Overflow;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;

  modport master (
    output ALU_Out, Negative, Zero, CarryOut, Overflow, in_valid, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  ALU_Out, Negative, Zero, CarryOut, Overflow, in_valid, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/alu_result_capture.sv
// Captures ALU result + NZCV into a DEPTH-entry FIFO with a registered head, plus saturating stats.
// Optional sticky flag accumulator is built only when ALU_CAPTURE_STICKY_EN is defined.
module alu_result_capture #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  alu_capture_if.slave  bus,
  input  logic          clr_stats,
  output logic [CW-1:0] op_count,
  output logic [CW-1:0] ovf_count,
  output logic [CW-1:0] err_count,
  output logic          err_pulse,
  output logic [3:0]    sticky_flags
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [CW-1:0]   STAT_ONE = CW'(1);

  typedef struct packed {
    logic [N-1:0] result;
    logic [3:0]   flags;  // {N,Z,C,V}
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  entry_t        head_q, head_d;
  logic          head_load;

  logic [CW-1:0] op_count_q, ovf_count_q, err_count_q;
  logic          err_pulse_q;

  entry_t in_entry;
  logic   full, empty, push, pop, flag_fail;

  assign in_entry  = '{result: bus.ALU_Out,
                       flags:  {bus.Negative, bus.Zero, bus.CarryOut, bus.Overflow}};
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign push      = bus.in_valid & ~full;
  assign pop       = ~empty & bus.out_ready;
  assign flag_fail = (bus.Zero != (bus.ALU_Out == '0)) | (bus.Negative != bus.ALU_Out[N-1]);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + STAT_ONE;
  endfunction

  // Head register tracks the FIFO front; the newly pushed entry becomes head when the queue
  // would otherwise be empty after this edge.
  always_comb begin
    head_d    = head_q;
    head_load = 1'b0;
    if (push && empty) begin
      head_d    = in_entry;
      head_load = 1'b1;
    end else if (pop && (count_q > CNT_ONE)) begin
      head_d    = mem_q[rd_ptr_q + PTR_ONE];
      head_load = 1'b1;
    end else if (pop && push) begin
      head_d    = in_entry;
      head_load = 1'b1;
    end
  end

  // NOTE: storage array carries no reset; validity is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (head_load) head_q <= head_d;
    end
  end

  // Clear wins over a same-cycle increment; err_pulse is a plain registered copy of a failing push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q  <= '0;
      ovf_count_q <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= push & flag_fail;
      if (clr_stats) begin
        op_count_q  <= '0;
        ovf_count_q <= '0;
        err_count_q <= '0;
      end else if (push) begin
        op_count_q <= sat_inc(op_count_q);
        if (bus.Overflow) ovf_count_q <= sat_inc(ovf_count_q);
        if (flag_fail)    err_count_q <= sat_inc(err_count_q);
      end
    end
  end

`ifdef ALU_CAPTURE_STICKY_EN
  logic [3:0] sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            sticky_q <= 4'b0000;
    else if (clr_stats) sticky_q <= 4'b0000;
    else if (push)      sticky_q <= sticky_q | in_entry.flags;
  end

  assign sticky_flags = sticky_q;
`else
  assign sticky_flags = 4'b0000;
`endif

  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_result = head_q.result;
  assign bus.out_flags  = head_q.flags;
  assign op_count       = op_count_q;
  assign ovf_count      = ovf_count_q;
  assign err_count      = err_count_q;
  assign err_pulse      = err_pulse_q;

endmodule

// File: tb/tb_alu_result_capture.sv
// Self-checking bench: a CW=8 and a CW=2 instance see identical stimulus and are compared
// against a queue-based reference model of the capture FIFO and its statistics.
module tb_alu_result_capture;
  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr_stats;
  always #5 clk = ~clk;

  alu_capture_if #(.N(N)) bus ();
  alu_capture_if #(.N(N)) sbus ();

  assign sbus.ALU_Out   = bus.ALU_Out;
  assign sbus.Negative  = bus.Negative;
  assign sbus.Zero      = bus.Zero;
  assign sbus.CarryOut  = bus.CarryOut;
  assign sbus.Overflow  = bus.Overflow;
  assign sbus.in_valid  = bus.in_valid;
  assign sbus.out_ready = bus.out_ready;

  logic [7:0] op_count, ovf_count, err_count;
  logic       err_pulse;
  logic [3:0] sticky_flags;
  logic [1:0] s_op_count, s_ovf_count, s_err_count;
  logic       s_err_pulse;
  logic [3:0] s_sticky_flags;

  alu_result_capture #(.N(N), .DEPTH(DEPTH), .CW(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clr_stats    (clr_stats),
    .op_count     (op_count),
    .ovf_count    (ovf_count),
    .err_count    (err_count),
    .err_pulse    (err_pulse),
    .sticky_flags (sticky_flags)
  );

  alu_result_capture #(.N(N), .DEPTH(DEPTH), .CW(2)) u_sat (
    .clk          (clk),
    .rst          (rst),
    .bus          (sbus),
    .clr_stats    (clr_stats),
    .op_count     (s_op_count),
    .ovf_count    (s_ovf_count),
    .err_count    (s_err_count),
    .err_pulse    (s_err_pulse),
    .sticky_flags (s_sticky_flags)
  );

  typedef struct {
    logic [3:0] res;
    logic [3:0] flg;
  } ent_t;

  ent_t       q[$];
  logic [3:0] held_res, held_flg;
  int         n_ops, n_ovf, n_err;
  logic       exp_pulse;
  logic [3:0] exp_sticky;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [3:0] good(input logic [3:0] r, input logic c, input logic v);
    return {r[3], (r == 4'h0), c, v};
  endfunction

  task automatic model_reset();
    q.delete();
    held_res   = '0;
    held_flg   = '0;
    n_ops      = 0;
    n_ovf      = 0;
    n_err      = 0;
    exp_pulse  = 1'b0;
    exp_sticky = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/in_ready"},  32'(bus.in_ready),   32'(q.size() < DEPTH));
    check({tag, "/out_valid"}, 32'(bus.out_valid),  32'(q.size() > 0));
    check({tag, "/out_result"}, 32'(bus.out_result), 32'(held_res));
    check({tag, "/out_flags"}, 32'(bus.out_flags),  32'(held_flg));
    check({tag, "/op_count"},  32'(op_count),  32'(sat(n_ops, 8)));
    check({tag, "/ovf_count"}, 32'(ovf_count), 32'(sat(n_ovf, 8)));
    check({tag, "/err_count"}, 32'(err_count), 32'(sat(n_err, 8)));
    check({tag, "/err_pulse"}, 32'(err_pulse), 32'(exp_pulse));
    check({tag, "/sticky"},    32'(sticky_flags), 32'(exp_sticky));
    check({tag, "/s_op_count"},  32'(s_op_count),  32'(sat(n_ops, 2)));
    check({tag, "/s_ovf_count"}, 32'(s_ovf_count), 32'(sat(n_ovf, 2)));
    check({tag, "/s_err_count"}, 32'(s_err_count), 32'(sat(n_err, 2)));
    check({tag, "/s_in_ready"},  32'(sbus.in_ready),   32'(q.size() < DEPTH));
    check({tag, "/s_out_result"}, 32'(sbus.out_result), 32'(held_res));
  endtask

  task automatic step(input string tag, input logic [3:0] res, input logic [3:0] flg,
                      input logic iv, input logic ordy, input logic clr);
    logic push, pop, fail;
    ent_t e;
    bus.ALU_Out   = res;
    {bus.Negative, bus.Zero, bus.CarryOut, bus.Overflow} = flg;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    clr_stats     = clr;
    push = iv && (q.size() < DEPTH);
    pop  = (q.size() > 0) && ordy;
    fail = (flg[2] != (res == 4'h0)) || (flg[3] != res[3]);
    e.res = res;
    e.flg = flg;
    @(posedge clk);
    #1;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    if (q.size() > 0) begin
      held_res = q[0].res;
      held_flg = q[0].flg;
    end
    exp_pulse = push && fail;
    if (clr) begin
      n_ops = 0;
      n_ovf = 0;
      n_err = 0;
    end else if (push) begin
      n_ops++;
      if (flg[0]) n_ovf++;
      if (fail)   n_err++;
    end
`ifdef ALU_CAPTURE_STICKY_EN
    if (clr)       exp_sticky = '0;
    else if (push) exp_sticky = exp_sticky | flg;
`endif
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 4'h0, 4'h0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    logic [3:0] r;
    rst           = 1'b1;
    clr_stats     = 1'b0;
    bus.ALU_Out   = '0;
    bus.Negative  = 1'b0;
    bus.Zero      = 1'b0;
    bus.CarryOut  = 1'b0;
    bus.Overflow  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single op
    step("single_push", 4'h1, 4'b0000, 1'b1, 1'b1, 1'b0);
    idle("single_pop", 1'b1);

    // Fill, refused fifth push, ordered drain
    for (int i = 0; i < 5; i++) begin
      r = 4'(i + 3);
      step("fill", r, good(r, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) idle("drain", 1'b1);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) begin
      r = 4'(12 - i);
      step("refill", r, good(r, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
    end
    step("full_pop", 4'h7, good(4'h7, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0);
    idle("after_full", 1'b0);
    for (int i = 0; i < 4; i++) idle("drain2", 1'b1);

    // Flag error: zero result with Z=0
    step("flag_err", 4'h0, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle("flag_err_next", 1'b1);

    // Overflow and saturation
    step("clr1", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      r = 4'(i + 1);
      step("ovf", r, good(r, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
    end
    step("clr2", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    step("clr_vs_push", 4'h2, good(4'h2, 1'b0, 1'b1), 1'b1, 1'b1, 1'b1);

    // Sticky accumulation
    step("clr3", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    step("sticky_n", 4'h8, 4'b1000, 1'b1, 1'b1, 1'b0);
    step("sticky_v", 4'h5, 4'b0001, 1'b1, 1'b1, 1'b0);
    idle("sticky_idle", 1'b1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [3:0] f;
      r = 4'($urandom);
      f = ($urandom_range(0, 3) == 0) ? 4'($urandom)
                                      : good(r, 1'($urandom), 1'($urandom));
      step("rand", r, f, ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 31) == 0));
    end

    // Reset with two entries buffered
    for (int i = 0; i < DEPTH; i++) idle("pre_rst_drain", 1'b1);
    step("pre_rst_a", 4'h9, good(4'h9, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
    step("pre_rst_b", 4'h6, good(4'h6, 1'b1, 1'b1), 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4'hA, good(4'hA, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0);
    idle("post_rst_pop", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
